dmem_responder: RTL and testbench

Multi-cycle data-memory responder serving the CPU MEM stage's load/store requests (MemRead/MemWrite, 32-bit address, 32-bit store data). It stores DEPTH 32-bit words and completes every access after a fixed LATENCY. It drives stall_o to freeze the pipeline while an access is outstanding, then pulses ack_o with load data. It replaces the single-cycle data memory behind the existing pipeline's hazard/stall path.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory behind the MEM stage.
// A request seen in IDLE is latched and answered LATENCY cycles later.
// stall_o freezes the pipeline while the access is outstanding.
// In the ack cycle, ack_o pulses together with the load data and err_o.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_nxt_s;
    logic            op_wr_r;
    logic            op_wr_nxt_s;
    logic [AW-1:0]   idx_r;
    logic [AW-1:0]   idx_nxt_s;
    logic [31:0]     wdata_r;
    logic [31:0]     wdata_nxt_s;
    logic            mis_r;
    logic            mis_nxt_s;

    logic            req_s;
    logic            stall_s;
    logic            ack_s;
    logic            err_s;
    logic            wr_en_s;
    logic [31:0]     rdata_s;

    // Word storage; deliberately not reset so contents survive rst_i.
    logic [31:0]     mem_r [DEPTH];

    // Address bits above the word index wrap and are not used.
    logic            unused_addr_s;
    assign unused_addr_s = ^addr_i[31:AW+2];

    assign req_s   = MemRead_i | MemWrite_i;
    assign data_o  = rdata_s;
    assign stall_o = stall_s;
    assign ack_o   = ack_s;
    assign err_o   = err_s;

    // Next-state, request capture and combinational outputs.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        op_wr_nxt_s = op_wr_r;
        idx_nxt_s   = idx_r;
        wdata_nxt_s = wdata_r;
        mis_nxt_s   = mis_r;
        stall_s     = 1'b0;
        ack_s       = 1'b0;
        err_s       = 1'b0;
        wr_en_s     = 1'b0;
        rdata_s     = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                // A request arriving while reset is held is never accepted.
                if (req_s && rst_i) begin
                    stall_s     = 1'b1;
                    state_nxt_s = BUSY;
                    cnt_nxt_s   = CNT_INIT;
                    op_wr_nxt_s = MemWrite_i;
                    idx_nxt_s   = addr_i[AW+1:2];
                    wdata_nxt_s = data_i;
                    mis_nxt_s   = (addr_i[1:0] != 2'b00);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r != 4'd0) begin
                    stall_s   = 1'b1;
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    ack_s       = 1'b1;
                    err_s       = mis_r;
                    state_nxt_s = IDLE;
                    wr_en_s     = op_wr_r & ~mis_r;
                    if (!op_wr_r && !mis_r) begin
                        rdata_s = mem_r[idx_r];
                    end else begin
                        rdata_s = 32'h0000_0000;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, countdown and latched request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            op_wr_r <= 1'b0;
            idx_r   <= '0;
            wdata_r <= 32'h0000_0000;
            mis_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            op_wr_r <= op_wr_nxt_s;
            idx_r   <= idx_nxt_s;
            wdata_r <= wdata_nxt_s;
            mis_r   <= mis_nxt_s;
        end
    end

    // Store commit at the end of the ack cycle; reset discards it.
    always_ff @(posedge clk_i) begin
        if (rst_i && wr_en_s) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH=32, LATENCY=4).
// A transaction-level model predicts each cycle's outputs.
// Directed accesses also compare against hand-computed constants.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(32), .LATENCY(L)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .stall_o    (stall_o),
        .ack_o      (ack_o),
        .err_o      (err_o)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] model_mem [32];
    bit          in_flight = 1'b0;
    int          ack_at    = 0;
    bit          t_wr      = 1'b0;
    int          t_idx     = 0;
    logic [31:0] t_data    = 32'h0;
    bit          t_mis     = 1'b0;
    int          cyc       = 0;
    bit          check_en  = 1'b0;

    // Model: accept in idle, complete L cycles later, commit stores.
    always @(posedge clk) begin
        if (!rst_i) begin
            in_flight = 1'b0;
        end else if (in_flight) begin
            if (cyc == ack_at) begin
                if (t_wr && !t_mis) model_mem[t_idx] = t_data;
                in_flight = 1'b0;
            end
        end else if (MemRead_i || MemWrite_i) begin
            in_flight = 1'b1;
            ack_at    = cyc + L;
            t_wr      = MemWrite_i;
            t_idx     = int'(addr_i[6:2]);
            t_data    = data_i;
            t_mis     = (addr_i[1:0] != 2'b00);
        end
        cyc++;
        check_en = 1'b1;
    end

    logic        e_stall, e_ack, e_err;
    logic [31:0] e_data;

    // Compare all outputs against the model in the middle of every cycle.
    always @(negedge clk) begin
        if (check_en) begin
            e_stall = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_data = 32'h0;
            if (in_flight) begin
                if (cyc < ack_at) begin
                    e_stall = 1'b1;
                end else begin
                    e_ack = 1'b1;
                    e_err = t_mis;
                    if (!t_wr && !t_mis) e_data = model_mem[t_idx];
                end
            end else begin
                e_stall = (MemRead_i || MemWrite_i) && rst_i;
            end
            check32("model stall_o", {31'b0, stall_o}, {31'b0, e_stall});
            check32("model ack_o",   {31'b0, ack_o},   {31'b0, e_ack});
            check32("model err_o",   {31'b0, err_o},   {31'b0, e_err});
            check32("model data_o",  data_o, e_data);
        end
    end

    // ---------------- stimulus ----------------
    // One access; starts just after a rising edge, ends just after the ack edge.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input bit chg, input logic [31:0] caddr, input logic [31:0] cdata,
                          output logic [31:0] rdata, output logic err, output int stalls);
        bit got;
        MemRead_i = rd; MemWrite_i = wr; addr_i = addr; data_i = data;
        stalls = 0; got = 1'b0; rdata = 32'h0; err = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack_o) begin
                got = 1'b1; rdata = data_o; err = err_o;
            end else if (stall_o) begin
                stalls++;
            end
            @(posedge clk); #1;
            if (chg && i == 1) begin
                addr_i = caddr; data_i = cdata;
            end
        end
        MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL access timeout: got no ack expected ack for addr %h", addr);
        end
    endtask

    task automatic do_store(input string name, input bit rd, input logic [31:0] addr,
                            input logic [31:0] data, input logic exp_err);
        logic [31:0] rdat; logic e; int s;
        access(rd, 1'b1, addr, data, 1'b0, 32'h0, 32'h0, rdat, e, s);
        check32({name, " err"},    {31'b0, e}, {31'b0, exp_err});
        check32({name, " stalls"}, 32'(s), 32'(L));
    endtask

    task automatic do_load(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rdat; logic e; int s;
        access(1'b1, 1'b0, addr, 32'h0, 1'b0, 32'h0, 32'h0, rdat, e, s);
        check32({name, " data"},   rdat, exp_data);
        check32({name, " err"},    {31'b0, e}, {31'b0, exp_err});
        check32({name, " stalls"}, 32'(s), 32'(L));
    endtask

    // Hold reset with a store request present; outputs must stay low.
    task automatic reset_hold(input int n);
        rst_i = 1'b0; MemWrite_i = 1'b1; addr_i = 32'h10; data_i = 32'hBAD0_BAD0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check32("reset stall_o", {31'b0, stall_o}, 32'h0);
            check32("reset ack_o",   {31'b0, ack_o},   32'h0);
            check32("reset err_o",   {31'b0, err_o},   32'h0);
            check32("reset data_o",  data_o,           32'h0);
            @(posedge clk); #1;
        end
        rst_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    endtask

    initial begin
        logic [31:0] rdat; logic e; int s;
        rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b1; addr_i = 32'h10; data_i = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        reset_hold(3);

        // Known contents for the locations later read back as "prior value".
        do_store("pre 0x24", 1'b0, 32'h24, 32'h2424_2424, 1'b0);
        do_store("pre 0x08", 1'b0, 32'h08, 32'h0808_0808, 1'b0);

        // Basic store then load.
        do_store("st 0x10", 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_load("ld 0x10", 32'h10, 32'hDEAD_BEEF, 1'b0);

        // Inputs changing while busy are ignored.
        access(1'b0, 1'b1, 32'h20, 32'h1111_1111, 1'b1, 32'h24, 32'h2222_2222, rdat, e, s);
        check32("st chg stalls", 32'(s), 32'(L));
        do_load("ld 0x20", 32'h20, 32'h1111_1111, 1'b0);
        do_load("ld 0x24", 32'h24, 32'h2424_2424, 1'b0);

        // Misaligned accesses flag an error and never touch memory.
        do_store("st 0x13", 1'b0, 32'h13, 32'h5555_5555, 1'b1);
        do_load("ld 0x12", 32'h12, 32'h0000_0000, 1'b1);
        do_load("ld 0x10 after mis", 32'h10, 32'hDEAD_BEEF, 1'b0);

        // Address wrap and simultaneous read/write request.
        do_store("st 0x80", 1'b0, 32'h80, 32'hA5A5_A5A5, 1'b0);
        do_load("ld 0x00 wrap", 32'h00, 32'hA5A5_A5A5, 1'b0);
        do_store("rdwr 0x04", 1'b1, 32'h04, 32'h0F0F_0F0F, 1'b0);
        do_load("ld 0x04", 32'h04, 32'h0F0F_0F0F, 1'b0);

        // Reset in the middle of a store discards it.
        MemWrite_i = 1'b1; addr_i = 32'h08; data_i = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b0; MemWrite_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        check32("post-reset stall_o", {31'b0, stall_o}, 32'h0);
        check32("post-reset ack_o",   {31'b0, ack_o},   32'h0);
        @(posedge clk); #1;
        do_load("ld 0x08 after reset", 32'h08, 32'h0808_0808, 1'b0);

        // Reset held with a store request performs no write.
        reset_hold(3);
        do_load("ld 0x10 after reset hold", 32'h10, 32'hDEAD_BEEF, 1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
